// File: rtl/abu_fetch_decode.sv
// rtl/abu_fetch_decode.sv - instruction fetch and compact-word decode for the branch-mode ABU
// Owns stall hold/replay, halt, sticky illegal-opcode flag and the stall-group select scan chain.
module abu_fetch_decode #(
   parameter int IM_ADDR_WIDTH    = 16,
   parameter int I_WIDTH          = 12,
   parameter int I_DECODED_WIDTH  = 16,
   parameter int NUM_STALL_GROUPS = 1
) (
   input  logic                        iClk,
   input  logic                        iReset,
   input  logic [IM_ADDR_WIDTH-1:0]    iPC,
   input  logic                        iHalted,
   input  logic [NUM_STALL_GROUPS-1:0] iStall,
   input  logic                        iConfigEnable,
   input  logic                        iConfigDataIn,
   output logic                        oConfigDataOut,
   output logic                        oIMemReq,
   output logic [IM_ADDR_WIDTH-1:0]    oIMemAddr,
   input  logic [I_WIDTH-1:0]          iIMemData,
   output logic [I_DECODED_WIDTH-1:0]  oDecodedInstruction,
   output logic                        oValid,
   output logic                        oHalted,
   output logic                        oIllegal,
   output logic [15:0]                 oStallCycles
);

   localparam int SGW        = (NUM_STALL_GROUPS > 1) ? $clog2(NUM_STALL_GROUPS) : 1;
   localparam int STALL_PADW = 1 << SGW;

   typedef enum logic [2:0] {
      ST_START,
      ST_FETCH,
      ST_STALL,
      ST_REPLAY,
      ST_HALTED
   } state_t;

   state_t            state_q, state_d;
   logic [13:0]       hold_q, hold_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic              illegal_q, illegal_d;
   logic [SGW-1:0]    cfg_q, cfg_d;
   logic [STALL_PADW-1:0] stall_pad;
   logic              stall_sel;
   logic              fetch_illegal;
   logic [13:0]       fetch_dec;
   logic [13:0]       out_dec;
   logic              req;

   // Decoded bit order: regA, immAddr, absRel, jump, brCond, accSigned, acc, rdImm, wrImm, dest, srcB[1:0], srcA[1:0]
   function automatic logic [13:0] decode(input logic [11:0] w);
      logic [3:0]  op;
      logic [5:0]  f;
      logic [13:0] d;
      op = w[11:8];
      f  = w[5:0];
      d  = '0;
      if (op inside {4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11}) begin
         d[13]   = f[3];
         d[4]    = f[2];
         d[3:2]  = f[1:0];
         d[1:0]  = w[7:6];
      end else if (op inside {[4'd4:4'd7], 4'd12}) begin
         d[12]   = 1'b1;
         d[7:2]  = (op == 4'd12) ? 6'd0 : f;
         d[1:0]  = w[7:6];
      end
      case (op)
         4'd1: begin
            d[7] = 1'b1;
            d[8] = f[4];
         end
         4'd2:                d[5]     = 1'b1;
         4'd3:                d[6]     = 1'b1;
         4'd4, 4'd8:          d[10]    = 1'b1;
         4'd5, 4'd9, 4'd12:   d[11:10] = 2'b11;
         4'd6, 4'd10:         d[9]     = 1'b1;
         4'd7, 4'd11: begin
            d[11] = 1'b1;
            d[9]  = 1'b1;
         end
         default: ;
      endcase
      return d;
   endfunction

   assign fetch_illegal = (iIMemData[11:8] >= 4'd13);
   assign fetch_dec     = fetch_illegal ? 14'd0 : decode(iIMemData[11:0]);

   // Pad the stall vector to a power of two so any select value indexes a defined bit.
   assign stall_pad = STALL_PADW'(iStall);
   assign stall_sel = stall_pad[cfg_q];

   generate
      if (SGW == 1) begin : g_cfg1
         assign cfg_d = iConfigDataIn;
      end else begin : g_cfgn
         assign cfg_d = {iConfigDataIn, cfg_q[SGW-1:1]};
      end
   endgenerate

   // Configuration survives iReset; it only moves when scanned.
   always_ff @(posedge iClk) begin
      if (iConfigEnable) cfg_q <= cfg_d;
   end
   assign oConfigDataOut = cfg_q[0];

   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         state_q     <= ST_START;
         hold_q      <= '0;
         stall_cnt_q <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         stall_cnt_q <= stall_cnt_d;
         illegal_q   <= illegal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START:  state_d = ST_FETCH;
         ST_FETCH: begin
            if (iHalted)        state_d = ST_HALTED;
            else if (stall_sel) state_d = ST_STALL;
         end
         ST_STALL: begin
            if (iHalted)         state_d = ST_HALTED;
            else if (!stall_sel) state_d = ST_REPLAY;
         end
         ST_REPLAY: state_d = stall_sel ? ST_STALL : ST_FETCH;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_START;
      endcase
   end

   always_comb begin
      hold_d      = hold_q;
      stall_cnt_d = stall_cnt_q;
      illegal_d   = illegal_q;
      if (state_q == ST_FETCH) begin
         hold_d = fetch_dec;
         if (fetch_illegal) illegal_d = 1'b1;
      end
      if ((state_q == ST_STALL) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_comb begin
      req     = 1'b0;
      out_dec = '0;
      oValid  = 1'b0;
      oHalted = 1'b0;
      case (state_q)
         ST_START:  req = 1'b1;
         ST_FETCH: begin
            req     = 1'b1;
            out_dec = fetch_dec;
            oValid  = !fetch_illegal;
         end
         ST_STALL:  out_dec = hold_q;
         ST_REPLAY: req = 1'b1;
         ST_HALTED: oHalted = 1'b1;
         default: ;
      endcase
   end

   // START is the reset state, so the request is masked while reset is held.
   assign oIMemReq            = req & iReset;
   assign oIMemAddr           = iPC;
   assign oDecodedInstruction = I_DECODED_WIDTH'(out_dec);
   assign oIllegal            = illegal_q;
   assign oStallCycles        = stall_cnt_q;

endmodule
